// File: rtl/fir_tap_accumulator.sv
// Streaming tap accumulator: sums TAPS signed products per frame, then
// arithmetic-shifts by SHIFT and saturates the result to OUT_WIDTH bits.
// Valid/ready on both sides; one output is held until downstream takes it.

// Parameterised ripple-carry adder (no carry in or out; the caller sizes the
// operands so that the sum cannot overflow).
module fir_rca_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end
endmodule

module fir_tap_accumulator #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned TAPS      = 8,
  parameter int unsigned SHIFT     = 3,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_sat,
  output logic [$clog2(TAPS):0]   tap_cnt
);
  localparam int unsigned CNT_W     = $clog2(TAPS) + 1;
  localparam int unsigned ACC_WIDTH = IN_WIDTH + $clog2(TAPS);
  // Compare width wide enough to hold both the scaled sum and the output limits.
  localparam int unsigned CW = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

  localparam logic signed [CW-1:0] MAXV = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MINV = {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       tap_cnt_q, tap_cnt_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0]   in_ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] scaled;
  logic signed [CW-1:0]   scaled_ext;
  logic                   accept;

  assign in_ext = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  fir_rca_adder #(.WIDTH(ACC_WIDTH)) u_add (
    .a_i   (acc_q),
    .b_i   (in_ext),
    .sum_o (sum)
  );

  assign sum_s      = sum;
  assign scaled     = sum_s >>> SHIFT;
  assign scaled_ext = {{(CW-ACC_WIDTH){scaled[ACC_WIDTH-1]}}, scaled};

  // out_valid is decoded from the state register rather than kept as a
  // separate flop; HOLD is exactly the "output pending" condition.
  assign in_ready  = ~rst & (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign tap_cnt   = tap_cnt_q;
  assign accept    = in_valid & in_ready;

  // State, accumulator and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      tap_cnt_q  <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tap_cnt_q  <= tap_cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // Next-state logic: accumulate, finalise (scale + saturate), hold, abort.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tap_cnt_d  = tap_cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (clear) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      tap_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_d     = in_ext;
            tap_cnt_d = CNT_W'(1);
            state_d   = S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            if (tap_cnt_q == CNT_W'(TAPS - 1)) begin
              if (scaled_ext > MAXV) begin
                out_data_d = MAXV[OUT_WIDTH-1:0];
                out_sat_d  = 1'b1;
              end else if (scaled_ext < MINV) begin
                out_data_d = MINV[OUT_WIDTH-1:0];
                out_sat_d  = 1'b1;
              end else begin
                out_data_d = scaled_ext[OUT_WIDTH-1:0];
                out_sat_d  = 1'b0;
              end
              acc_d     = '0;
              tap_cnt_d = '0;
              state_d   = S_HOLD;
            end else begin
              acc_d     = sum;
              tap_cnt_d = tap_cnt_q + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Directed bench for fir_tap_accumulator: two instances (SHIFT=3 and SHIFT=0)
// share the same stimulus so each frame checks both scaling and saturation.
module tb_fir_tap_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready3, in_ready0;
  logic        out_valid3, out_valid0;
  logic [15:0] out_data3, out_data0;
  logic        out_sat3, out_sat0;
  logic [3:0]  tap_cnt3, tap_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_tap_accumulator #(.IN_WIDTH(16), .TAPS(8), .SHIFT(3), .OUT_WIDTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
    .out_data(out_data3), .out_sat(out_sat3), .tap_cnt(tap_cnt3)
  );

  fir_tap_accumulator #(.IN_WIDTH(16), .TAPS(8), .SHIFT(0), .OUT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0), .tap_cnt(tap_cnt0)
  );

  typedef struct packed {
    logic [7:0][15:0] s;
    logic [15:0]      d3;
    logic             s3;
    logic [15:0]      d0;
    logic             s0;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one frame back-to-back; returns at the negedge after the final accept.
  task automatic feed_frame(input logic [7:0][15:0] s);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic [15:0] d3, input logic s3,
                           input logic [15:0] d0, input logic s0);
    chk({nm, " valid3"}, out_valid3, 1'b1);
    chk({nm, " data3"},  out_data3,  d3);
    chk({nm, " sat3"},   out_sat3,   s3);
    chk({nm, " valid0"}, out_valid0, 1'b1);
    chk({nm, " data0"},  out_data0,  d0);
    chk({nm, " sat0"},   out_sat0,   s0);
  endtask

  task automatic run_vec(input int k);
    string nm;
    nm = $sformatf("vec%0d", k);
    feed_frame(tv[k].s);
    chk({nm, " inready_hold"}, in_ready3, 1'b0);
    check_out(nm, tv[k].d3, tv[k].s3, tv[k].d0, tv[k].s0);
    @(negedge clk);
    chk({nm, " valid_after"},   out_valid3, 1'b0);
    chk({nm, " inready_after"}, in_ready3,  1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{s: {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8},
              d3: 16'h0004, s3: 1'b0, d0: 16'h0024, s0: 1'b0};
    tv[1] = '{s: {8{16'hFFFD}}, d3: 16'hFFFD, s3: 1'b0, d0: 16'hFFE8, s0: 1'b0};
    tv[2] = '{s: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFF7},
              d3: 16'hFFFE, s3: 1'b0, d0: 16'hFFF7, s0: 1'b0};
    tv[3] = '{s: {8{16'h7FFF}}, d3: 16'h7FFF, s3: 1'b0, d0: 16'h7FFF, s0: 1'b1};
    tv[4] = '{s: {8{16'h8000}}, d3: 16'h8000, s3: 1'b0, d0: 16'h8000, s0: 1'b1};
    tv[5] = '{s: {16'h03E8, 16'hF830, 16'h0BB8, 16'hF060, 16'h1388, 16'hE890, 16'h1B58, 16'hE0C0},
              d3: 16'hFE0C, s3: 1'b0, d0: 16'hF060, s0: 1'b0};
    tv[6] = '{s: {8{16'h1000}}, d3: 16'h1000, s3: 1'b0, d0: 16'h7FFF, s0: 1'b1};
    tv[7] = '{s: {8{16'hF000}}, d3: 16'hF000, s3: 1'b0, d0: 16'h8000, s0: 1'b0};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst out_valid", out_valid3, 1'b0);
      chk("rst in_ready",  in_ready3,  1'b0);
    end
    chk("rst out_data", out_data3, 16'h0);
    chk("rst out_sat",  out_sat3,  1'b0);
    chk("rst tap_cnt",  tap_cnt3,  4'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready",  in_ready3,  1'b1);
    chk("post-rst out_valid", out_valid3, 1'b0);
    chk("post-rst tap_cnt",   tap_cnt3,   4'd0);

    // Table of back-to-back frames
    for (int k = 0; k < 8; k++) run_vec(k);

    // Bubbles between samples, then backpressure in HOLD
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(i + 1);
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 7) chk($sformatf("bubble tap_cnt%0d", i), tap_cnt3, 4'(i + 1));
    end
    check_out("bubble", 16'h0004, 1'b0, 16'h0024, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0005;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp in_ready",  in_ready3,  1'b0);
      chk("bp out_valid", out_valid3, 1'b1);
      chk("bp out_data",  out_data3,  16'h0004);
      chk("bp tap_cnt",   tap_cnt3,   4'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs out_valid", out_valid3, 1'b0);
    chk("hs in_ready",  in_ready3,  1'b1);
    chk("hs tap_cnt",   tap_cnt3,   4'd0);
    @(negedge clk);
    chk("idle accept tap_cnt", tap_cnt3, 4'd1);
    in_data = 16'h0001;
    for (int c = 0; c < 7; c++) @(negedge clk);
    in_valid = 1'b0;
    check_out("resume", 16'h0001, 1'b0, 16'h000C, 1'b0);
    @(negedge clk);

    // clear after 3 accepts, with a sample presented in the clear cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'(i + 1);
    end
    @(negedge clk);
    chk("pre-clear tap_cnt", tap_cnt3, 4'd3);
    clear   = 1'b1;
    in_data = 16'd100;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear tap_cnt",  tap_cnt3,  4'd0);
    chk("clear in_ready", in_ready3, 1'b1);
    run_vec(0);

    // clear while holding an output
    out_ready = 1'b0;
    feed_frame(tv[5].s);
    chk("hold-clear valid before", out_valid3, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("hold-clear out_valid", out_valid3, 1'b0);
    chk("hold-clear out_data",  out_data3,  16'hFE0C);
    chk("hold-clear in_ready",  in_ready3,  1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold-clear no hs", out_valid3, 1'b0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0100;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst tap_cnt",  tap_cnt3,  4'd0);
    chk("async rst out_data", out_data3, 16'h0);
    chk("async rst in_ready", in_ready3, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(5);
    run_vec(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_tap_accumulator.md
Name: fir_tap_accumulator

Overview:
Streaming accumulate stage that consumes per-tap products and sums TAPS consecutive samples into one filter output. The add path reuses the team's parameterised ripple-carry adder, sign-extended to the accumulator width. A scale (arithmetic right shift) and a saturate step reduce the full-precision sum to OUT_WIDTH. Valid/ready handshakes on both sides let it sit between the tap multiplier array and the output register/FIFO.

Parameters:
IN_WIDTH, 16, signed width of each incoming tap product
TAPS, 8, samples summed per output; legal range 2..256
SHIFT, 3, arithmetic right shift applied to the final sum before saturation; legal range 0..ACC_WIDTH-1
OUT_WIDTH, 16, signed width of the output sample
(localparam) ACC_WIDTH = IN_WIDTH + clog2(TAPS); the sum cannot overflow at this width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort: drops the partial sum and any pending output
in_valid  in  1  in_data is valid
in_ready  out  1  stage can accept a sample
in_data  in  IN_WIDTH  signed tap product
out_valid  out  1  out_data/out_sat are valid
out_ready  in  1  downstream accepts the output
out_data  out  OUT_WIDTH  scaled, saturated sum
out_sat  out  1  out_data was clipped
tap_cnt  out  clog2(TAPS)+1  samples accepted in the current frame (debug)

Behaviour:
- Reset (rst high, asynchronous): state IDLE; acc=0; tap_cnt=0; out_valid=0; out_data=0; out_sat=0. in_ready is forced 0 while rst is high.
- States:
  - IDLE: in_ready=1.
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready. Cycles where in_valid is low leave all state unchanged.
- IDLE + accept: acc<=sext(in_data); tap_cnt<=1; go to ACCUM.
- ACCUM + accept with tap_cnt<TAPS-1: acc<=acc+sext(in_data); tap_cnt++.
- ACCUM + accept with tap_cnt==TAPS-1 (final sample):
  - full = acc+sext(in_data), computed at ACC_WIDTH bits.
  - scaled = full >>> SHIFT (floor, sign-preserving).
  - If scaled > 2^(OUT_WIDTH-1)-1: out_data=max, out_sat=1.
  - If scaled < -2^(OUT_WIDTH-1): out_data=min, out_sat=1.
  - Otherwise: out_data=scaled[OUT_WIDTH-1:0], out_sat=0.
  - All registered; out_valid=1 on the next cycle. Latency is 1 cycle from the final accept.
  - acc<=0, tap_cnt<=0, go to HOLD.
- HOLD: out_data and out_sat stay stable until out_valid & out_ready. On that handshake: out_valid<=0, go to IDLE.
  - No sample is accepted in the handshake cycle, because in_ready=0 throughout HOLD.
  - Peak throughput is one output per TAPS+1 cycles.
- clear (synchronous; priority over all other actions except rst):
  - Next state IDLE; acc=0; tap_cnt=0; out_valid=0.
  - out_data and out_sat keep their last values.
  - A sample presented in the clear cycle is discarded, even if in_ready was 1.
- rst asserted mid-frame or in HOLD: immediate return to reset values; the partial sum and pending output are lost.
- in_ready depends only on state and rst, with no combinational path from out_ready or in_valid.

Test Plan:
- Reset: hold rst 3 cycles, then release -> out_valid=0, out_data=0, out_sat=0, tap_cnt=0 during and after reset; in_ready=0 during reset and 1 after release.
- Basic sum (TAPS=8, SHIFT=3, out_ready=1): feed 1..8 back-to-back -> out_valid rises exactly 1 cycle after the 8th accept with out_data=4 (36>>>3) and out_sat=0; next cycle IDLE and in_ready=1.
- Negative/floor: 8 samples of -3, SHIFT=3 -> -24>>>3 = -3. Then 7 zeros and one -9 -> -9>>>3 = -2; out_sat=0 in both frames.
- Saturation (SHIFT=0): 8x 0x7FFF -> sum 262136 clips to out_data=0x7FFF, out_sat=1. Then 8x 0x8000 -> sum -262144 clips to 0x8000, out_sat=1.
- Backpressure/bubbles:
  - Insert in_valid gaps between samples -> tap_cnt advances only on accepts and the result is unchanged.
  - Hold out_ready=0 for 5 HOLD cycles with in_valid=1 -> in_ready=0, no sample consumed, out_data stable.
  - Raise out_ready -> exactly one handshake, then the next sample is accepted in IDLE the following cycle.
- Abort:
  - clear after 3 accepts -> tap_cnt=0, the next frame of 1..8 yields 4.
  - clear in HOLD -> out_valid drops next cycle, no handshake occurs.
  - rst pulse mid-frame -> outputs go to reset values asynchronously and the next frame computes correctly.
